// File: rtl/switches_to_leds_db.sv
// N-channel switch conditioner. Each channel has a synchroniser, a debouncer and
// rise/fall event pulses. The LEDs run in direct mode or toggle-on-press mode.
module switches_to_leds_db #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_switch,
  input  logic         i_mode,
  input  logic         i_clear,
  output logic [N-1:0] o_led,
  output logic [N-1:0] o_switch_db,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CW-1:0]          cnt_reg;
      logic                   db_reg;
      logic                   db_d_reg;
      logic                   led_reg;
      logic                   led_next;
      logic                   sync;
      logic                   rise;
      logic                   fall;

      assign sync = sync_reg[SYNC_STAGES-1];
      assign rise = db_reg & ~db_d_reg;
      assign fall = ~db_reg & db_d_reg;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_switch[gi]};
        end
      end

      // Any cycle where sync agrees with db discards the run, so a bounce restarts the timer.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_reg  <= '0;
          db_reg   <= 1'b0;
          db_d_reg <= 1'b0;
        end else begin
          db_d_reg <= db_reg;
          if (sync == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            db_reg  <= sync;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      // Direct mode keeps the latch tracking db, so entering toggle mode starts glitch-free.
      always_comb begin
        led_next = led_reg;
        if (!i_mode) begin
          led_next = db_reg;
        end else if (i_clear) begin
          led_next = 1'b0;
        end else if (rise) begin
          led_next = ~led_reg;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          led_reg <= 1'b0;
        end else begin
          led_reg <= led_next;
        end
      end

      assign o_led[gi]       = led_reg;
      assign o_switch_db[gi] = db_reg;
      assign o_rise[gi]      = rise;
      assign o_fall[gi]      = fall;
    end
  endgenerate

endmodule

// File: tb/tb_switches_to_leds_db.sv
// Bench for switches_to_leds_db: a hand-derived vector table, directed corner sequences,
// then random stimulus checked against a window-based reference model.
module tb_switches_to_leds_db;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         clr;
  logic [N-1:0] sw;
  logic [N-1:0] led;
  logic [N-1:0] sdb;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  always #5 clk = ~clk;

  switches_to_leds_db #(.N(N), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst), .i_switch(sw), .i_mode(mode), .i_clear(clr),
    .o_led(led), .o_switch_db(sdb), .o_rise(rise), .o_fall(fall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sync is the raw input delayed SS edges (zeros after reset).
  // db takes the sync value once the last DB pre-edge sync samples all disagree with it.
  logic [N-1:0] m_db, m_dbp, m_led;
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_hist[$];

  task automatic model_edge(input logic r, input logic [N-1:0] s, input logic md, input logic c);
    logic [N-1:0] sy;
    logic [N-1:0] rise_pre;
    logic [N-1:0] flip;
    if (r) begin
      m_db  = '0;
      m_dbp = '0;
      m_led = '0;
      m_pipe.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      m_hist.delete();
    end else begin
      sy = m_pipe.pop_front();
      m_pipe.push_back(s);
      m_hist.push_back(sy);
      if (m_hist.size() > DB) m_hist.delete(0);
      rise_pre = m_db & ~m_dbp;
      if (!md)     m_led = m_db;
      else if (c)  m_led = '0;
      else         m_led = m_led ^ rise_pre;
      flip = '0;
      if (m_hist.size() == DB) begin
        flip = '1;
        foreach (m_hist[k]) flip = flip & (m_hist[k] ^ m_db);
      end
      m_dbp = m_db;
      m_db  = m_db ^ flip;
    end
  endtask

  task automatic step();
    logic         r;
    logic [N-1:0] s;
    logic         md;
    logic         c;
    r = rst; s = sw; md = mode; c = clr;
    @(posedge clk);
    model_edge(r, s, md, c);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4*N-1:0] outs();
    return {led, sdb, rise, fall};
  endfunction

  function automatic logic [4*N-1:0] model_outs();
    return {m_led, m_db, m_db & ~m_dbp, ~m_db & m_dbp};
  endfunction

  typedef struct {
    int           reps;
    logic         r;
    logic [N-1:0] s;
    logic [N-1:0] e_led;
    logic [N-1:0] e_db;
    logic [N-1:0] e_rise;
    logic [N-1:0] e_fall;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [N-1:0] prev_led;
    logic [N-1:0] new_led;
    int           rise_cnt;

    // reset with switches high, then a clean press/release of bit 0 in direct mode
    tbl[0]  = '{3, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{5, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    tbl[3]  = '{1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[4]  = '{5, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[5]  = '{1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    tbl[6]  = '{1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{5, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    tbl[10] = '{1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{5, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[12] = '{1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tbl[13] = '{1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    mode = 1'b0; clr = 1'b0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        rst = tbl[i].r;
        sw  = tbl[i].s;
        step();
        chk($sformatf("row%0d_edge%0d", i, k), 32'(outs()),
            32'({tbl[i].e_led, tbl[i].e_db, tbl[i].e_rise, tbl[i].e_fall}));
      end
      $display("row %0d: rst=%b sw=%b for %0d edge(s), outs=%h", i, tbl[i].r, tbl[i].s, tbl[i].reps, outs());
    end

    // bouncing bit 1: runs of 3 never reach the 4-cycle threshold
    for (int i = 0; i < 30; i++) begin
      sw = (((i / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
      step();
      chk($sformatf("bounce_%0d", i), 32'({sdb[1], rise[1], fall[1]}), 32'(3'b000));
    end
    sw = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("bounce_hold_db_%0d", k), 32'(sdb), 32'((k >= 6) ? 4'b0010 : 4'b0000));
      chk($sformatf("bounce_hold_rise_%0d", k), 32'(rise), 32'((k == 6) ? 4'b0010 : 4'b0000));
    end
    chk("bounce_hold_led", 32'(led), 32'(4'b0010));
    sw = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bounce_release", 32'(outs()), 32'(model_outs()));
    end
    $display("bounce sequence: db=%b led=%b", sdb, led);

    // toggle mode: three press/release cycles on bit 2
    mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      prev_led = (p % 2 == 1) ? 4'b0100 : 4'b0000;
      new_led  = prev_led ^ 4'b0100;
      sw = 4'b0100;
      for (int k = 1; k <= 10; k++) begin
        step();
        chk($sformatf("tog%0d_press_led_%0d", p, k), 32'(led), 32'((k >= 7) ? new_led : prev_led));
        chk($sformatf("tog%0d_press_rise_%0d", p, k), 32'(rise), 32'((k == 6) ? 4'b0100 : 4'b0000));
      end
      sw = 4'b0000;
      for (int k = 1; k <= 10; k++) begin
        step();
        chk($sformatf("tog%0d_rel_led_%0d", p, k), 32'(led), 32'(new_led));
        chk($sformatf("tog%0d_rel_fall_%0d", p, k), 32'(fall), 32'((k == 6) ? 4'b0100 : 4'b0000));
      end
      $display("toggle press %0d: led=%b", p, led);
    end

    // clear beats a simultaneous rise, then direct mode reloads from db
    sw = 4'b0001;
    for (int k = 0; k < 10; k++) step();
    chk("clr_setup_led", 32'(led), 32'(4'b0101));
    sw = 4'b1001;
    for (int k = 0; k < 6; k++) step();
    chk("clr_rise3", 32'(rise), 32'(4'b1000));
    chk("clr_led_before", 32'(led), 32'(4'b0101));
    clr = 1'b1;
    step();
    chk("clr_wins", 32'(led), 32'(4'b0000));
    clr = 1'b0;
    sw  = 4'b1000;
    for (int k = 0; k < 10; k++) step();
    chk("clr_hold_led", 32'(led), 32'(4'b0000));
    chk("clr_hold_db", 32'(sdb), 32'(4'b1000));
    mode = 1'b0;
    step();
    chk("to_direct_led", 32'(led), 32'(4'b1000));
    $display("clear priority sequence: led=%b db=%b", led, sdb);

    // reset in the middle of a debounce
    sw = 4'b0000;
    for (int k = 0; k < 8; k++) step();
    chk("rstmid_idle", 32'(outs()), 32'(16'h0000));
    sw = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rstmid_pre_%0d", k), 32'(sdb), 32'(4'b0000));
    end
    rst = 1'b1;
    step();
    chk("rstmid_in_reset", 32'(outs()), 32'(16'h0000));
    rst = 1'b0;
    rise_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise[0]) rise_cnt++;
      if (k <= 7) chk($sformatf("rstmid_db_%0d", k), 32'(sdb), 32'((k >= 6) ? 4'b0001 : 4'b0000));
    end
    chk("rstmid_single_rise", 32'(rise_cnt), 32'(1));
    $display("reset mid-debounce sequence: db=%b rises=%0d", sdb, rise_cnt);

    // random stimulus against the reference model
    for (int b = 0; b < 40; b++) begin
      for (int e = 0; e < 20; e++) begin
        if ($urandom_range(5, 0) == 0) sw[$urandom_range(N-1, 0)] = ~sw[$urandom_range(N-1, 0)];
        if ($urandom_range(5, 0) == 0) sw[$urandom_range(N-1, 0)] = $urandom_range(1, 0) == 1;
        if ($urandom_range(39, 0) == 0) mode = ~mode;
        clr = ($urandom_range(7, 0) == 0);
        rst = ($urandom_range(249, 0) == 0);
        step();
        chk($sformatf("rand_b%0d_e%0d", b, e), 32'(outs()), 32'(model_outs()));
        chk($sformatf("rand_excl_b%0d_e%0d", b, e), 32'(rise & fall), 32'(m_db & ~m_dbp & ~m_db & m_dbp));
      end
      $display("random burst %0d: sw=%b mode=%b led=%b db=%b", b, sw, mode, led, sdb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
